ssp_tx_serializer_p: RTL and testbench

Parametrised successor to the fixed 8-bit SSP transmit serializer. It converts parallel words of DATA_WIDTH bits into a TI-style synchronous serial frame: an FSS pulse, then the data bits. Everything runs on i_PCLK, and the serial clock is generated as clock-enable ticks. A one-word holding register with valid/ready handshake lets frames run back-to-back with no gap. The block sits between the TX FIFO and the SSP pads.

---
 rtl/ssp_tx_serializer_p_if.sv | 24 ++
 rtl/ssp_tx_serializer_p.sv | 236 +++++++++++++++++++++++
 tb/tb_ssp_tx_serializer_p.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssp_tx_serializer_p_if.sv
// Word handshake between the TX FIFO side and the SSP transmit serializer.
// The master offers a word with its bit order; the slave signals when its holding register is empty.
interface ssp_tx_serializer_p_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] i_TXDATA;
    logic                  i_TX_VALID;
    logic                  i_LSB_FIRST;
    logic                  o_TX_READY;

    modport master (
        output i_TXDATA,
        output i_TX_VALID,
        output i_LSB_FIRST,
        input  o_TX_READY
    );

    modport slave (
        input  i_TXDATA,
        input  i_TX_VALID,
        input  i_LSB_FIRST,
        output o_TX_READY
    );
endinterface

// File: rtl/ssp_tx_serializer_p.sv
// TI-style SSP transmit serializer: FSS pulse then DATA_WIDTH bits, back-to-back via a one-word holding register.
// Define SSP_TX_PARITY_EN to append an even-parity bit after the data bits of every frame.
module ssp_tx_serializer_p #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2
) (
    input  logic                  i_PCLK,
    input  logic                  i_CLEAR,
    ssp_tx_serializer_p_if.slave  tx_if,
    output logic                  o_SSPCLKOUT,
    output logic                  o_SSPFSSOUT,
    output logic                  o_SSPTXD,
    output logic                  o_SSPOE_B,
    output logic                  o_BUSY
);

    localparam int HALF  = CLK_DIV / 2;
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FSYNC  = 3'd1,
        ST_SHIFT  = 3'd2,
`ifdef SSP_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_TAIL   = 3'd3
    } state_t;

    // Serial clock divider
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_sclk;
    logic             w_div_end;
    logic             w_rise;
    logic             w_fall;

    assign w_div_end = (r_div_cnt == DIV_W'(HALF - 1));
    assign w_rise    = w_div_end & ~r_sclk;
    assign w_fall    = w_div_end &  r_sclk;

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_PCLK or posedge i_CLEAR) begin
        if (i_CLEAR) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
        end else if (w_div_end) begin
            r_div_cnt <= '0;
            r_sclk    <= ~r_sclk;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Holding register
    logic                  r_hold_full;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  r_hold_lsb;
    logic                  w_load;

    always_ff @(posedge i_PCLK or posedge i_CLEAR) begin
        if (i_CLEAR) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
            r_hold_lsb  <= 1'b0;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end else if (tx_if.i_TX_VALID && !r_hold_full) begin
            r_hold_full <= 1'b1;
            r_hold_data <= tx_if.i_TXDATA;
            r_hold_lsb  <= tx_if.i_LSB_FIRST;
        end
    end

    assign tx_if.o_TX_READY = ~r_hold_full;

    // Frame FSM and shift datapath
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic                  r_lsb;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_fss;
    logic                  r_txd;
    logic                  r_data_on;
    logic                  r_oe_b;
`ifdef SSP_TX_PARITY_EN
    logic                  r_par;
    logic                  w_par_nxt;
`endif

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_shreg_nxt;
    logic                  w_lsb_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_fss_nxt;
    logic                  w_txd_nxt;
    logic                  w_data_on_nxt;
    logic                  w_eof;
    logic                  w_head_bit;
    logic [DATA_WIDTH-1:0] w_shreg_adv;

    // Bit leaving the shift register next, and the register after it has gone.
    assign w_head_bit  = r_lsb ? r_shreg[0] : r_shreg[DATA_WIDTH-1];
    assign w_shreg_adv = r_lsb ? {1'b0, r_shreg[DATA_WIDTH-1:1]}
                               : {r_shreg[DATA_WIDTH-2:0], 1'b0};

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_lsb_nxt     = r_lsb;
        w_cnt_nxt     = r_cnt;
        w_fss_nxt     = r_fss;
        w_txd_nxt     = r_txd;
        w_data_on_nxt = r_data_on;
        w_eof         = 1'b0;
        w_load        = 1'b0;
`ifdef SSP_TX_PARITY_EN
        w_par_nxt     = r_par;
`endif

        case (r_state)
            ST_IDLE: begin
                w_load = w_rise & r_hold_full;
            end
            ST_FSYNC: begin
                if (w_rise) begin
                    w_fss_nxt     = 1'b0;
                    w_txd_nxt     = w_head_bit;
                    w_shreg_nxt   = w_shreg_adv;
                    w_cnt_nxt     = CNT_W'(1);
                    w_data_on_nxt = 1'b1;
                    w_state_nxt   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_rise) begin
                    w_txd_nxt     = w_head_bit;
                    w_shreg_nxt   = w_shreg_adv;
                    w_data_on_nxt = 1'b1;
                    if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        w_cnt_nxt = '0;
`ifdef SSP_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_eof = 1'b1;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
`ifdef SSP_TX_PARITY_EN
            ST_PARITY: begin
                if (w_rise) begin
                    w_txd_nxt = r_par;
                    w_eof     = 1'b1;
                end
            end
`endif
            ST_TAIL: begin
                if (w_rise) begin
                    w_txd_nxt     = 1'b0;
                    w_data_on_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // The last bit's tick doubles as the next frame's FSS when a word is already waiting.
        if (w_eof) begin
            if (r_hold_full) begin
                w_load = 1'b1;
            end else begin
                w_state_nxt = ST_TAIL;
            end
        end

        if (w_load) begin
            w_fss_nxt   = 1'b1;
            w_shreg_nxt = r_hold_data;
            w_lsb_nxt   = r_hold_lsb;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_FSYNC;
`ifdef SSP_TX_PARITY_EN
            w_par_nxt   = ^r_hold_data;
`endif
        end
    end

    always_ff @(posedge i_PCLK or posedge i_CLEAR) begin
        if (i_CLEAR) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_lsb     <= 1'b0;
            r_cnt     <= '0;
            r_fss     <= 1'b0;
            r_txd     <= 1'b0;
            r_data_on <= 1'b0;
`ifdef SSP_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_lsb     <= w_lsb_nxt;
            r_cnt     <= w_cnt_nxt;
            r_fss     <= w_fss_nxt;
            r_txd     <= w_txd_nxt;
            r_data_on <= w_data_on_nxt;
`ifdef SSP_TX_PARITY_EN
            r_par     <= w_par_nxt;
`endif
        end
    end

    // Output enable follows the data line half a serial period late, on fall ticks only.
    always_ff @(posedge i_PCLK or posedge i_CLEAR) begin
        if (i_CLEAR) begin
            r_oe_b <= 1'b1;
        end else if (w_fall) begin
            r_oe_b <= ~r_data_on;
        end
    end

    assign o_SSPCLKOUT = r_sclk;
    assign o_SSPFSSOUT = r_fss;
    assign o_SSPTXD    = r_txd;
    assign o_SSPOE_B   = r_oe_b;
    assign o_BUSY      = (r_state != ST_IDLE) | r_hold_full;

endmodule

// File: tb/tb_ssp_tx_serializer_p.sv
// Scoreboard bench for ssp_tx_serializer_p: instance 0 uses CLK_DIV=2, instance 1 uses CLK_DIV=6.
// A monitor decodes serial frames from the pins and compares them with hand-computed expected words.
module tb_ssp_tx_serializer_p;

    localparam int DW = 8;
`ifdef SSP_TX_PARITY_EN
    localparam int FB = DW + 1;
`else
    localparam int FB = DW;
`endif

    typedef struct packed {
        logic [DW-1:0] bits;
        logic          par;
    } exp_t;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    ssp_tx_serializer_p_if #(.DATA_WIDTH(DW)) tx_if2 ();
    ssp_tx_serializer_p_if #(.DATA_WIDTH(DW)) tx_if6 ();

    logic [1:0] sclk, fss, txd, oe_b, busy;

    ssp_tx_serializer_p #(.DATA_WIDTH(DW), .CLK_DIV(2)) dut2 (
        .i_PCLK(clk), .i_CLEAR(clr), .tx_if(tx_if2),
        .o_SSPCLKOUT(sclk[0]), .o_SSPFSSOUT(fss[0]), .o_SSPTXD(txd[0]),
        .o_SSPOE_B(oe_b[0]), .o_BUSY(busy[0])
    );

    ssp_tx_serializer_p #(.DATA_WIDTH(DW), .CLK_DIV(6)) dut6 (
        .i_PCLK(clk), .i_CLEAR(clr), .tx_if(tx_if6),
        .o_SSPCLKOUT(sclk[1]), .o_SSPFSSOUT(fss[1]), .o_SSPTXD(txd[1]),
        .o_SSPOE_B(oe_b[1]), .o_BUSY(busy[1])
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    exp_t q0[$];
    exp_t q1[$];

    task automatic expect_frame(input int d, input logic [DW-1:0] bits, input logic par);
        exp_t e;
        e.bits = bits;
        e.par  = par;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor state, one slot per instance
    bit            prev_sclk  [2] = '{0, 0};
    bit            collecting [2] = '{0, 0};
    bit            data_on    [2] = '{0, 0};
    int            nbits      [2] = '{0, 0};
    int            rise_idx   [2] = '{0, 0};
    int            starts     [2] = '{0, 0};
    logic [FB-1:0] sh         [2];
    int            start_t0[$];
    int            end_t0[$];

    task automatic frame_done(input int d, input logic [FB-1:0] s);
        exp_t          e;
        logic [DW-1:0] data;
        int            n;
`ifdef SSP_TX_PARITY_EN
        data = s[FB-1:1];
`else
        data = s;
`endif
        n = (d == 0) ? q0.size() : q1.size();
        check($sformatf("dut%0d frame expected", d), 32'(n != 0), 1);
        if (n != 0) begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("dut%0d frame data", d), 32'(data), 32'(e.bits));
`ifdef SSP_TX_PARITY_EN
            check($sformatf("dut%0d parity bit", d), 32'(s[0]), 32'(e.par));
`endif
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (clr) begin
                    prev_sclk[d]  = 1'b0;
                    collecting[d] = 1'b0;
                    data_on[d]    = 1'b0;
                    nbits[d]      = 0;
                end else begin
                    if (!prev_sclk[d] && sclk[d]) begin
                        rise_idx[d]++;
                        data_on[d] = collecting[d];
                        if (collecting[d]) begin
                            sh[d] = {sh[d][FB-2:0], txd[d]};
                            nbits[d]++;
                            if (nbits[d] == FB) begin
                                collecting[d] = 1'b0;
                                if (d == 0) end_t0.push_back(rise_idx[d]);
                                frame_done(d, sh[d]);
                            end
                        end
                        if (fss[d]) begin
                            collecting[d] = 1'b1;
                            nbits[d]      = 0;
                            starts[d]++;
                            if (d == 0) start_t0.push_back(rise_idx[d]);
                        end
                    end else if (prev_sclk[d] && !sclk[d] && d == 0) begin
                        check("dut0 oe_b at fall tick", 32'(oe_b[0]), 32'(!data_on[0]));
                    end
                    prev_sclk[d] = sclk[d];
                end
            end
        end
    end

    // All stimulus runs at negedge+1 so it never races the monitor.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic [DW-1:0] data, input logic lsb, input logic v);
        if (d == 0) begin
            tx_if2.i_TXDATA = data; tx_if2.i_LSB_FIRST = lsb; tx_if2.i_TX_VALID = v;
        end else begin
            tx_if6.i_TXDATA = data; tx_if6.i_LSB_FIRST = lsb; tx_if6.i_TX_VALID = v;
        end
    endtask

    task automatic release_valid(input int d);
        if (d == 0) tx_if2.i_TX_VALID = 1'b0;
        else        tx_if6.i_TX_VALID = 1'b0;
    endtask

    // Offers a word and returns half a cycle after the accepting edge, valid still high.
    task automatic send(input int d, input logic [DW-1:0] data, input logic lsb);
        int   n = 0;
        logic rdy;
        drive(d, data, lsb, 1'b1);
        rdy = (d == 0) ? tx_if2.o_TX_READY : tx_if6.o_TX_READY;
        while (!rdy && n < 500) begin
            tick();
            n++;
            rdy = (d == 0) ? tx_if2.o_TX_READY : tx_if6.o_TX_READY;
        end
        check($sformatf("dut%0d accepts 0x%0h", d, data), 32'(rdy), 1);
        tick();
    endtask

    task automatic drain(input int d, input int budget);
        int n = 0;
        int qs;
        qs = (d == 0) ? q0.size() : q1.size();
        while ((qs != 0 || busy[d] || !oe_b[d]) && n < budget) begin
            tick();
            n++;
            qs = (d == 0) ? q0.size() : q1.size();
        end
        repeat (4) tick();
        qs = (d == 0) ? q0.size() : q1.size();
        check($sformatf("dut%0d all frames seen", d), 32'(qs), 0);
        check($sformatf("dut%0d idle after drain", d), 32'(busy[d]), 0);
    endtask

    initial begin
        int lat;
        int n;

        clr = 1'b1;
        drive(0, '0, 1'b0, 1'b0);
        drive(1, '0, 1'b0, 1'b0);
        repeat (3) tick();
        check("reset sclk",   32'(sclk[0]), 0);
        check("reset fss",    32'(fss[0]), 0);
        check("reset txd",    32'(txd[0]), 0);
        check("reset oe_b",   32'(oe_b[0]), 1);
        check("reset ready",  32'(tx_if2.o_TX_READY), 1);
        check("reset busy",   32'(busy[0]), 0);
        check("reset ready6", 32'(tx_if6.o_TX_READY), 1);
        clr = 1'b0;
        repeat (2) tick();

        // 0xA5 MSB first
        expect_frame(0, 8'hA5, 1'b0);
        send(0, 8'hA5, 1'b0);
        check("ready low after accept", 32'(tx_if2.o_TX_READY), 0);
        check("busy after accept", 32'(busy[0]), 1);
        release_valid(0);
        drain(0, 200);
        check("txd low when idle", 32'(txd[0]), 0);
        check("oe_b high when idle", 32'(oe_b[0]), 1);

        // LSB first: 0xA5 is a bit palindrome, 0x01 goes out as 1 then seven zeros
        expect_frame(0, 8'hA5, 1'b0);
        send(0, 8'hA5, 1'b1);
        release_valid(0);
        drain(0, 200);
        expect_frame(0, 8'h80, 1'b1);
        send(0, 8'h01, 1'b1);
        release_valid(0);
        drain(0, 200);

        // Back-to-back 0x3C, 0xC3 with valid held throughout
        start_t0.delete();
        end_t0.delete();
        expect_frame(0, 8'h3C, 1'b0);
        expect_frame(0, 8'hC3, 1'b0);
        send(0, 8'h3C, 1'b0);
        send(0, 8'hC3, 1'b0);
        release_valid(0);
        drain(0, 200);
        check("b2b frame starts", 32'(start_t0.size()), 2);
        check("b2b frame ends", 32'(end_t0.size()), 2);
        if (start_t0.size() == 2 && end_t0.size() == 2) begin
            check("b2b fss on last bit", 32'(start_t0[1]), 32'(end_t0[0]));
            check("b2b span in periods", 32'(end_t0[1] - start_t0[0]), 32'(2 * FB));
        end

        // CLK_DIV=6: three words against a one-word holding register
        expect_frame(1, 8'h11, 1'b0);
        expect_frame(1, 8'h22, 1'b0);
        expect_frame(1, 8'h33, 1'b0);
        send(1, 8'h11, 1'b0);
        release_valid(1);
        lat = 0;
        while (!fss[1] && lat < 20) begin
            tick();
            lat++;
        end
        check("dut6 fss latency in range", 32'(lat >= 1 && lat <= 7), 1);
        send(1, 8'h22, 1'b0);
        check("dut6 ready low while full", 32'(tx_if6.o_TX_READY), 0);
        check("dut6 busy while full", 32'(busy[1]), 1);
        send(1, 8'h33, 1'b0);
        check("dut6 third accepted after second loads", 32'(starts[1]), 2);
        release_valid(1);
        drain(1, 600);

        // Reset in the middle of 0xFF, then a clean 0x81
        send(0, 8'hFF, 1'b0);
        release_valid(0);
        n = 0;
        while (nbits[0] != 5 && n < 200) begin
            tick();
            n++;
        end
        check("reached bit 4", 32'(nbits[0]), 5);
        check("txd high mid 0xFF", 32'(txd[0]), 1);
        clr = 1'b1;
        #1;
        check("async reset sclk",  32'(sclk[0]), 0);
        check("async reset fss",   32'(fss[0]), 0);
        check("async reset txd",   32'(txd[0]), 0);
        check("async reset oe_b",  32'(oe_b[0]), 1);
        check("async reset ready", 32'(tx_if2.o_TX_READY), 1);
        check("async reset busy",  32'(busy[0]), 0);
        repeat (2) tick();
        clr = 1'b0;
        tick();
        expect_frame(0, 8'h81, 1'b0);
        send(0, 8'h81, 1'b0);
        release_valid(0);
        drain(0, 200);

`ifdef SSP_TX_PARITY_EN
        expect_frame(0, 8'h07, 1'b1);
        send(0, 8'h07, 1'b0);
        release_valid(0);
        drain(0, 200);
        expect_frame(0, 8'h03, 1'b0);
        send(0, 8'h03, 1'b0);
        release_valid(0);
        drain(0, 200);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
